// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the uart_tx arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, SEND, LOCK)
//   UART_BYTE_W : width of one transmitted byte
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Scans requesters starting one above the
// pointer (wrapping modulo NUM_REQ) and reports the first active one.
// Ports:
//   i_req    [NUM_REQ-1:0]  request vector
//   i_ptr    [REQ_W-1:0]    last served requester
//   o_onehot [NUM_REQ-1:0]  one-hot winner (all zero when no request)
//   o_idx    [REQ_W-1:0]    winner index (0 when no request)
//   o_any                   at least one request present
// ---------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [REQ_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [REQ_W-1:0]   o_idx,
    output logic               o_any
);

    int v_idx;

    // Walk the rotated priority order; the first hit wins and blocks the rest.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        v_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(i_ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_any && (v_idx == i) && i_req[i]) begin
                    o_any       = 1'b1;
                    o_onehot[i] = 1'b1;
                    o_idx       = REQ_W'(i);
                end else begin
                    o_any = o_any;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx byte transmitter between NUM_REQ requesters. Grants are
// round-robin at packet granularity: the owner keeps the transmitter until it
// sends a byte flagged last. One byte is in flight at a time (tx_valid/tx_done).
// Optional feature macro: UART_ARB_TIMEOUT_EN -- releases a stalled packet
// lock after TIMEOUT idle cycles and pulses timeout_o.
// Ports:
//   clk, rst_i                 clock, synchronous active-high reset
//   req_valid_i/data_i/last_i  per-requester byte offer (data packed 8 bits each)
//   req_ready_o                one-hot accept, combinational
//   tx_data_o, tx_valid_o      byte and valid toward uart_tx
//   tx_done_i                  byte finished by uart_tx
//   grant_o                    one-hot current owner, 0 when idle
//   busy_o                     arbiter not idle
//   timeout_o                  one-cycle pulse on lock release by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [UART_BYTE_W-1:0]         tx_data_o,
    output logic                           tx_valid_o,
    input  logic                           tx_done_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    arb_state_t             r_state;
    logic [UART_BYTE_W-1:0] r_byte;
    logic                   r_last;
    logic [REQ_W-1:0]       r_owner;
    logic [REQ_W-1:0]       r_ptr;

    logic [NUM_REQ-1:0]     w_pick_oh;
    logic [REQ_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [REQ_W-1:0]       w_sel_idx;
    logic [UART_BYTE_W-1:0] w_sel_data;
    logic                   w_sel_last;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_accept;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_timeout;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_pick (
        .i_req    (req_valid_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // The byte source is the fresh pick in IDLE and the locked owner otherwise.
    assign w_sel_idx = (r_state == IDLE) ? w_pick_idx : r_owner;

    // Decode owner one-hot and mux the selected requester's byte/last.
    always_comb begin
        w_owner_oh = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == REQ_W'(i)) begin
                w_owner_oh[i] = 1'b1;
            end else begin
                w_owner_oh[i] = 1'b0;
            end
            if (w_sel_idx == REQ_W'(i)) begin
                w_sel_data = req_data_i[i*UART_BYTE_W +: UART_BYTE_W];
                w_sel_last = req_last_i[i];
            end else begin
                w_sel_last = w_sel_last;
            end
        end
    end

    // Accept strobe: pick in IDLE, owner only in LOCK, never in SEND or reset.
    always_comb begin
        w_ready = '0;
        if (rst_i) begin
            w_ready = '0;
        end else begin
            case (r_state)
                IDLE:    w_ready = w_pick_any ? w_pick_oh : '0;
                LOCK:    w_ready = w_owner_oh & req_valid_i;
                default: w_ready = '0;
            endcase
        end
    end

    assign w_accept = |w_ready;

    // Arbiter FSM with byte, owner, pointer and optional lock timeout.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_byte    <= '0;
            r_last    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= REQ_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_byte  <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_owner <= w_pick_idx;
                        r_state <= SEND;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEND: begin
                    if (tx_done_i) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_ptr   <= r_owner;
                        end else begin
                            r_state <= LOCK;
                        end
                    end else begin
                        r_state <= SEND;
                    end
                end
                LOCK: begin
                    if (w_accept) begin
                        r_byte  <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_state <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        // Stalled owner: give up the lock after TIMEOUT idle cycles.
                        if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_state   <= IDLE;
                            r_ptr     <= r_owner;
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_state <= LOCK;
                        end
`else
                        r_state <= LOCK;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = w_ready;
    assign tx_data_o   = r_byte;
    assign tx_valid_o  = (r_state == SEND) && !tx_done_i;
    assign busy_o      = (r_state != IDLE);
    assign grant_o     = (r_state != IDLE) ? w_owner_oh : '0;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o   = r_timeout;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_done;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .REQ_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_done_i(tx_done), .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
    );

    // behavioural model: who owns the transmitter, is a byte outstanding
    int         m_owner, m_ptr, m_cnt, m_age, m_dwait;
    bit         m_inflight, m_last, m_to;
    logic [7:0] m_byte;

    // per-requester packet queues (ring buffers)
    logic [8:0] qmem [N][64];
    int         qh [N];
    int         qt [N];

    bit         rnd, force_done;
    logic [N-1:0] stall;
    int         to_seen;
    int         n_pass = 0;
    int         n_chk  = 0;
    int         log_own[$];
    int         log_byte[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    function automatic void push(input int r, input logic [7:0] b, input bit l);
        qmem[r][qt[r] % 64] = {l, b};
        qt[r]++;
    endfunction

    function automatic int own_at(input int k);
        return (k < log_own.size()) ? log_own[k] : -1;
    endfunction

    function automatic int byte_at(input int k);
        return (k < log_byte.size()) ? log_byte[k] : -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (qh[i] != qt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_age = 0; m_dwait = 0;
        m_inflight = 1'b0; m_last = 1'b0; m_to = 1'b0; m_byte = 8'h00;
    endtask

    task automatic take(input int r);
        m_byte     = req_data[8*r +: 8];
        m_last     = req_last[r];
        m_inflight = 1'b1;
        m_age      = 0;
        m_dwait    = rnd ? $urandom_range(0, 4) : 4;
        m_cnt      = 0;
        qh[r]++;
    endtask

    // One clock: drive inputs, compare DUT against model, then advance model.
    task automatic cycle();
        int           pick;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_grant;
        logic [8:0]   f;
        for (int i = 0; i < N; i++) begin
            f = qmem[i][qh[i] % 64];
            req_valid[i] = (qh[i] != qt[i]) && !stall[i] && (!rnd || ($urandom_range(0, 2) != 0));
            req_data[8*i +: 8] = (qh[i] != qt[i]) ? f[7:0] : 8'($urandom);
            req_last[i] = (qh[i] != qt[i]) ? f[8] : 1'($urandom);
        end
        if (m_inflight) tx_done = (m_age == m_dwait);
        else            tx_done = force_done || (rnd && ($urandom_range(0, 7) == 0));
        #3;
        pick = -1;
        for (int k = 1; k <= N; k++)
            if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        exp_ready = '0;
        if (!rst) begin
            if (m_owner < 0) begin
                if (pick >= 0) exp_ready[pick] = 1'b1;
            end else if (!m_inflight && req_valid[m_owner]) begin
                exp_ready[m_owner] = 1'b1;
            end
        end
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("ready", 32'(req_ready), 32'(exp_ready));
        chk("tx_valid", 32'(tx_valid), 32'(m_inflight && !tx_done));
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_inflight) chk("tx_data", 32'(tx_data), 32'(m_byte));
        to_seen += int'(timeout);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (pick >= 0) begin
                    m_owner = pick;
                    take(pick);
                end
            end else if (m_inflight) begin
                if (tx_done) begin
                    log_own.push_back(m_owner);
                    log_byte.push_back(int'(m_byte));
                    m_inflight = 1'b0;
                    if (m_last) begin
                        m_ptr   = m_owner;
                        m_owner = -1;
                    end
                end else begin
                    m_age++;
                end
            end else if (req_valid[m_owner]) begin
                take(m_owner);
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                if (m_cnt == TO - 1) begin
                    m_ptr = m_owner; m_owner = -1; m_to = 1'b1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
`endif
            end
        end
        #1;
    endtask

    task automatic run_until_idle(input string nm, input int maxc);
        bit ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            cycle();
            if (m_owner < 0 && all_empty()) begin ok = 1'b1; break; end
        end
        chk(nm, 32'(ok), 32'(1'b1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) qh[i] = qt[i];
    endtask

    initial begin
        bit ok;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        stall = '0; rnd = 1'b0; force_done = 1'b0; to_seen = 0;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        #3;  // back to posedge+1 phase
        @(posedge clk); #1;

        // tx_done in IDLE is ignored
        force_done = 1'b1; cycle(); force_done = 1'b0;
        cycle();
        chk("idle_done_busy", 32'(busy), 32'h0);

        // single requester, three-byte packet
        log_own.delete(); log_byte.delete();
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        run_until_idle("a_idle", 100);
        chk("a_b0", 32'(byte_at(0)), 32'h11);
        chk("a_b1", 32'(byte_at(1)), 32'h22);
        chk("a_b2", 32'(byte_at(2)), 32'h33);
        chk("a_own2", 32'(own_at(2)), 32'h0);

        // round-robin over four one-byte packets
        do_reset();
        log_own.delete(); log_byte.delete();
        for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
        push(0, 8'hA4, 1'b1);
        run_until_idle("b_idle", 200);
        for (int k = 0; k < 5; k++) chk("b_order", 32'(own_at(k)), 32'(k % N));

        // locked owner blocks another requester
        do_reset();
        log_own.delete(); log_byte.delete();
        push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b0); push(1, 8'hC3, 1'b1);
        push(2, 8'hD1, 1'b1);
        run_until_idle("c_idle", 200);
        chk("c_own0", 32'(own_at(0)), 32'h1);
        chk("c_own2", 32'(own_at(2)), 32'h1);
        chk("c_own3", 32'(own_at(3)), 32'h2);
        chk("c_b3", 32'(byte_at(3)), 32'hD1);

        // owner stalls in LOCK while req3 waits; tx_done pulsed in LOCK
        do_reset();
        log_own.delete(); log_byte.delete(); to_seen = 0;
        push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b0); push(1, 8'hE3, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            cycle();
            if (log_own.size() == 1) begin ok = 1'b1; break; end
        end
        chk("d_first", 32'(ok), 32'h1);
        stall[1] = 1'b1;
        push(3, 8'hF1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            force_done = (c == 3);
            cycle();
        end
        force_done = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        chk("d_to_seen", 32'(to_seen), 32'h1);
        chk("d_busy", 32'(busy), 32'h0);
        chk("d_own1", 32'(own_at(1)), 32'h3);
`else
        chk("d_to_seen", 32'(to_seen), 32'h0);
        chk("d_busy", 32'(busy), 32'h1);
        chk("d_grant", 32'(grant), 32'h2);
        chk("d_nlog", 32'(log_own.size()), 32'h1);
`endif
        stall[1] = 1'b0;
        run_until_idle("d_idle", 200);
`ifdef UART_ARB_TIMEOUT_EN
        chk("d_own3", 32'(own_at(3)), 32'h1);
`else
        chk("d_own3", 32'(own_at(3)), 32'h3);
`endif

        // reset in the middle of a byte
        do_reset();
        push(2, 8'h5A, 1'b0); push(2, 8'h5B, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (m_inflight && m_age == 2) begin ok = 1'b1; break; end
        end
        chk("f_inflight", 32'(ok), 32'h1);
        do_reset();
        chk("f_tx_valid", 32'(tx_valid), 32'h0);
        chk("f_busy", 32'(busy), 32'h0);
        chk("f_grant", 32'(grant), 32'h0);
        chk("f_tx_data", 32'(tx_data), 32'h0);
        chk("f_timeout", 32'(timeout), 32'h0);
        log_own.delete(); log_byte.delete();
        push(3, 8'h3C, 1'b1); push(0, 8'h0C, 1'b1);
        run_until_idle("f_idle", 100);
        chk("f_own0", 32'(own_at(0)), 32'h0);
        chk("f_own1", 32'(own_at(1)), 32'h3);

        // randomized traffic
        rnd = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r;
                int len;
                r   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 3);
                if (qt[r] - qh[r] < 48)
                    for (int j = 0; j < len; j++) push(r, 8'($urandom), (j == len - 1));
            end
            cycle();
        end
        rnd = 1'b0;
        run_until_idle("r_idle", 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
